// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: six-digit 7-segment scan controller (HH:MM:SS).
// A single BCD decode path is shared across all digits. Digits and blink mask
// are snapshotted once per frame. Each digit slot starts with an anti-ghosting
// blank gap, and selected digits blink for time-set mode.
// Optional feature: define SEG_SCAN_ZERO_BLANK_EN to blank a leading zero on the
// most significant digit (hours tens).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    output logic [6:0]              led_7_seg,
    output logic [NUM_DIGITS-1:0]   digit_sel_o,
    output logic                    frame_o
);

    localparam int IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int CW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

`ifdef SEG_SCAN_ZERO_BLANK_EN
    localparam bit ZERO_BLANK = 1'b1;
`else
    localparam bit ZERO_BLANK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                         state, nxt_state;
    logic [IW-1:0]                  idx, nxt_idx;
    logic [CW-1:0]                  cnt, nxt_cnt;
    logic [FW-1:0]                  fcnt, nxt_fcnt;
    logic                           blink_ph, nxt_ph;
    logic [NUM_DIGITS-1:0][3:0]     snap_dig, nxt_dig;
    logic [NUM_DIGITS-1:0]          snap_mask, nxt_mask;
    logic                           wrap;

    logic [6:0]                     nxt_seg;
    logic [NUM_DIGITS-1:0]          nxt_sel;
    logic                           nxt_frame;
    logic [3:0]                     cur_bcd;

    // Active-low a..g on bits 6..0; non-BCD codes stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // State, datapath and registered outputs; outputs are computed from the
    // next state so select and segments change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            fcnt        <= '0;
            blink_ph    <= 1'b0;
            snap_dig    <= '0;
            snap_mask   <= '0;
            led_7_seg   <= 7'b1111111;
            digit_sel_o <= '1;
            frame_o     <= 1'b0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            cnt         <= nxt_cnt;
            fcnt        <= nxt_fcnt;
            blink_ph    <= nxt_ph;
            snap_dig    <= nxt_dig;
            snap_mask   <= nxt_mask;
            led_7_seg   <= nxt_seg;
            digit_sel_o <= nxt_sel;
            frame_o     <= nxt_frame;
        end
    end

    // Next-state: slot counter spans blank gap + show; frame wrap re-snapshots
    // inputs and advances the blink frame counter. Disable parks in IDLE but
    // leaves the blink phase and frame counter alone.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        nxt_fcnt  = fcnt;
        nxt_ph    = blink_ph;
        nxt_dig   = snap_dig;
        nxt_mask  = snap_mask;
        wrap      = 1'b0;
        if (!en_i) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt_state = BLANK;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                    nxt_dig   = digits_i;
                    nxt_mask  = blink_mask_i;
                end
                BLANK: begin
                    nxt_cnt = cnt + 1'b1;
                    if (cnt == CW'(BLANK_CYCLES - 1))
                        nxt_state = SHOW;
                end
                SHOW: begin
                    if (cnt == CW'(SCAN_DIV - 1)) begin
                        nxt_state = BLANK;
                        nxt_cnt   = '0;
                        if (idx == IW'(NUM_DIGITS - 1)) begin
                            nxt_idx  = '0;
                            wrap     = 1'b1;
                            nxt_dig  = digits_i;
                            nxt_mask = blink_mask_i;
                            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                                nxt_fcnt = '0;
                                nxt_ph   = ~blink_ph;
                            end else begin
                                nxt_fcnt = fcnt + 1'b1;
                            end
                        end else begin
                            nxt_idx = idx + 1'b1;
                        end
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Output decode: everything dark except in SHOW; blink and leading-zero
    // blanking kill segments but keep the select so per-digit duty is uniform.
    always_comb begin
        nxt_seg   = 7'b1111111;
        nxt_sel   = '1;
        nxt_frame = wrap;
        cur_bcd   = nxt_dig[nxt_idx];
        if (nxt_state == SHOW) begin
            nxt_sel[nxt_idx] = 1'b0;
            nxt_seg          = seg_decode(cur_bcd);
            if (nxt_ph && nxt_mask[nxt_idx])
                nxt_seg = 7'b1111111;
            if (ZERO_BLANK && nxt_idx == IW'(NUM_DIGITS - 1) && cur_bcd == 4'd0)
                nxt_seg = 7'b1111111;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed checks of seg_scan_ctrl against a
// time-based reference model (slot/frame derived from cycles since enable).
module tb_seg_scan_ctrl;

    localparam int N  = 6;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FP = N * SD;

`ifdef SEG_SCAN_ZERO_BLANK_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [4*N-1:0] digits;
    logic [N-1:0]  mask;
    logic [6:0]    seg;
    logic [N-1:0]  sel;
    logic          frame;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int            run = -1;   // cycles since enable edge, -1 when dark/idle
    int            wraps = 0;  // frame wraps since reset
    logic [4*N-1:0] sd = '0;
    logic [N-1:0]  sm = '0;
    logic [6:0]    e_seg;
    logic [N-1:0]  e_sel;
    logic          e_frame;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .digits_i(digits),
        .blink_mask_i(mask), .led_7_seg(seg), .digit_sel_o(sel), .frame_o(frame)
    );

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // One clock: update the model from inputs seen at the edge, then move to
    // the falling edge where outputs are sampled.
    task automatic tick();
        int pos, slot, v;
        @(posedge clk);
        if (rst) begin
            run = -1; wraps = 0;
        end else if (!en) begin
            run = -1;
        end else if (run < 0) begin
            run = 0; sd = digits; sm = mask;
        end else begin
            run++;
            if (run % FP == 0) begin
                wraps++; sd = digits; sm = mask;
            end
        end
        e_seg = 7'b1111111; e_sel = '1; e_frame = 1'b0;
        if (run >= 0) begin
            pos = run % SD;
            slot = (run / SD) % N;
            e_frame = (run > 0) && (run % FP == 0);
            if (pos >= BC) begin
                e_sel[slot] = 1'b0;
                v = int'(sd[4*slot +: 4]);
                e_seg = ref_seg(v);
                if (((wraps / BF) % 2 == 1) && sm[slot]) e_seg = 7'b1111111;
                if (ZB && slot == N - 1 && v == 0) e_seg = 7'b1111111;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; digits = 24'h123456; mask = '0;
        repeat (3) begin
            tick();
            nvec++;
            if ({seg, sel, frame} !== {7'b1111111, 6'b111111, 1'b0}) begin
                nerr++;
                $display("FAIL reset: got seg=%b sel=%b frame=%b, expected 1111111/111111/0", seg, sel, frame);
            end
        end
    endtask

    task automatic test_scan();
        int pulses = 0;
        rst = 1'b0;
        for (int i = 0; i < 2 * FP + 4; i++) begin
            tick();
            if (frame === 1'b1) pulses++;
            nvec++;
            if ({seg, sel, frame} !== {e_seg, e_sel, e_frame}) begin
                nerr++;
                $display("FAIL scan t=%0d: got seg=%b sel=%b frame=%b, expected %b/%b/%b",
                         run, seg, sel, frame, e_seg, e_sel, e_frame);
            end
        end
        // two wraps happened in 2*FP+4 cycles after the start-up frame
        nvec++;
        if (pulses != 2) begin
            nerr++;
            $display("FAIL scan_frame_count: got %0d pulses, expected 2", pulses);
        end
    endtask

    task automatic test_snapshot();
        bit found = 1'b0;
        for (int i = 0; i < 2 * FP && !found; i++) begin
            if (run >= 0 && (run % FP) / SD == 2 && run % SD >= BC) found = 1'b1;
            else tick();
        end
        nvec++;
        if (!found) begin
            nerr++;
            $display("FAIL snapshot_wait: got timeout, expected digit 2 SHOW");
        end
        digits = 24'h000000;
        for (int i = 0; i < 2 * FP; i++) begin
            tick();
            nvec++;
            if ({seg, sel, frame} !== {e_seg, e_sel, e_frame}) begin
                nerr++;
                $display("FAIL snapshot t=%0d: got seg=%b sel=%b frame=%b, expected %b/%b/%b",
                         run, seg, sel, frame, e_seg, e_sel, e_frame);
            end
        end
    endtask

    task automatic test_blink();
        rst = 1'b1; digits = 24'h888888; mask = 6'b000011;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4 * FP + 2; i++) begin
            tick();
            nvec++;
            if ({seg, sel, frame} !== {e_seg, e_sel, e_frame}) begin
                nerr++;
                $display("FAIL blink t=%0d w=%0d: got seg=%b sel=%b frame=%b, expected %b/%b/%b",
                         run, wraps, seg, sel, frame, e_seg, e_sel, e_frame);
            end
            // frames 2-3 blank digit 0 with its select still driven
            if (wraps == 2 && run % FP == BC) begin
                nvec++;
                if ({sel, seg} !== {6'b111110, 7'b1111111}) begin
                    nerr++;
                    $display("FAIL blink_dig0: got sel=%b seg=%b, expected 111110/1111111", sel, seg);
                end
            end
        end
    endtask

    task automatic test_bad_bcd();
        rst = 1'b1; digits = 24'h12345A; mask = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < FP + 2; i++) begin
            tick();
            nvec++;
            if ({seg, sel, frame} !== {e_seg, e_sel, e_frame}) begin
                nerr++;
                $display("FAIL bad_bcd t=%0d: got seg=%b sel=%b frame=%b, expected %b/%b/%b",
                         run, seg, sel, frame, e_seg, e_sel, e_frame);
            end
            if (run == BC) begin
                nvec++;
                if ({sel, seg} !== {6'b111110, 7'b1111111}) begin
                    nerr++;
                    $display("FAIL bad_bcd_dig0: got sel=%b seg=%b, expected 111110/1111111", sel, seg);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        bit found = 1'b0;
        rst = 1'b1; digits = 24'h975310; mask = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2 * FP && !found; i++) begin
            tick();
            if (run >= 0 && (run % FP) / SD == 3 && run % SD == BC + 2) found = 1'b1;
        end
        nvec++;
        if (!found) begin
            nerr++;
            $display("FAIL en_drop_wait: got timeout, expected third SHOW cycle of digit 3");
        end
        en = 1'b0;
        tick();
        nvec++;
        if ({seg, sel, frame} !== {7'b1111111, 6'b111111, 1'b0}) begin
            nerr++;
            $display("FAIL en_drop_dark: got seg=%b sel=%b frame=%b, expected 1111111/111111/0", seg, sel, frame);
        end
        repeat (3) tick();
        en = 1'b1;
        for (int i = 0; i < FP + 4; i++) begin
            tick();
            nvec++;
            if ({seg, sel, frame} !== {e_seg, e_sel, e_frame}) begin
                nerr++;
                $display("FAIL en_restart t=%0d: got seg=%b sel=%b frame=%b, expected %b/%b/%b",
                         run, seg, sel, frame, e_seg, e_sel, e_frame);
            end
            if (i < FP && frame !== 1'b0) begin
                nerr++;
                $display("FAIL en_restart_frame t=%0d: got frame=%b, expected 0", run, frame);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            else rst = 1'b0;
            if ($urandom_range(0, 99) < 3) en = ~en;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            if ($urandom_range(0, 15) == 0) digits = $urandom;
            if ($urandom_range(0, 31) == 0) mask = N'($urandom);
            tick();
            nvec++;
            if ({seg, sel, frame} !== {e_seg, e_sel, e_frame}) begin
                nerr++;
                $display("FAIL random i=%0d t=%0d: got seg=%b sel=%b frame=%b, expected %b/%b/%b",
                         i, run, seg, sel, frame, e_seg, e_sel, e_frame);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; digits = '0; mask = '0;
        test_reset();
        test_scan();
        test_snapshot();
        test_blink();
        test_bad_bcd();
        test_en_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
